// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: DIGIT bits per cycle, result after N=WIDTH/DIGIT cycles.
// Operands are accepted only in IDLE. The result is held in DONE until out_ready is high.
module serial_addsub #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = $clog2(N) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_reg, b_reg;
   logic             carry;
   logic [CW-1:0]    count;
   logic [DIGIT:0]   dsum;
   logic             msb_cin;
   logic             last_digit;
   logic             accept;

   assign dsum = {1'b0, a_reg[DIGIT-1:0]} + {1'b0, b_reg[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
   // The sum bit equals a ^ b ^ carry-in, so the carry into the digit MSB can be recovered from it.
   assign msb_cin    = dsum[DIGIT-1] ^ a_reg[DIGIT-1] ^ b_reg[DIGIT-1];
   assign last_digit = (count == CW'(N - 1));
   assign accept     = (state == IDLE) && in_valid;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)   state_nxt = RUN;
         RUN:     if (last_digit) state_nxt = DONE;
         DONE:    if (out_ready)  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg <= '0;
         b_reg <= '0;
         carry <= 1'b0;
         count <= '0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else if (accept) begin
         a_reg <= a;
         b_reg <= sub ? ~b : b;
         carry <= sub;
         count <= '0;
      end else if (state == RUN) begin
         // Result digits enter at the MSB end, so after N shifts digit 0 sits at the LSB.
         sum   <= WIDTH'({dsum[DIGIT-1:0], sum} >> DIGIT);
         a_reg <= a_reg >> DIGIT;
         b_reg <= b_reg >> DIGIT;
         carry <= dsum[DIGIT];
         count <= count + CW'(1);
         if (last_digit) begin
            cout <= dsum[DIGIT];
            ovf  <= dsum[DIGIT] ^ msb_cin;
         end
      end
   end

endmodule
